// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit period, counter sizing.
// Used by the transmitter and by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA_BURST = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4
    } uart_state_e;

    // 10 MHz / 521 gives 19200 baud.
    localparam int unsigned CLKS_PER_BIT_DEF = 521;

    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; clr_i holds it at zero.
// bit_tick_o is a flop that is high exactly while the count sits on its last value. No backpressure.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clr_i,
    output logic                                 bit_tick_o,
    output logic [cnt_width(CLKS_PER_BIT)-1:0]   cnt_o
);

    localparam int unsigned     CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // The tick is registered from the next count so it lines up with cnt_q == LAST.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= !clr_i && (cnt_d == LAST);
        end
    end

    assign bit_tick_o = tick_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit; start bit one edge after accept.
// Accepts a byte only in IDLE (tx_ready); upstream holds tx_valid until accepted, nothing is queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned   CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    uart_state_e   state_q;
    logic [7:0]    data_q;
    logic [2:0]    bit_idx_q;
    logic          tx_out_q;
    logic          done_q;
    logic          bit_tick;
    logic [CW-1:0] bit_cnt;
    logic          parity_bit;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i      (tx_clk),
        .rst_i      (rst),
        .clr_i      (state_q == IDLE),
        .bit_tick_o (bit_tick),
        .cnt_o      (bit_cnt)
    );

    assign parity_bit = (^data_q) ^ PARITY_ODD;

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_idx_q <= '0;
            tx_out_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            // Raised one cycle early so the pulse covers the final stop-bit cycle.
            done_q <= (state_q == STOP) && (bit_cnt == PRE_LAST);
            case (state_q)
                IDLE: begin
                    tx_out_q <= 1'b1;
                    if (tx_valid) begin
                        data_q    <= tx_data;
                        bit_idx_q <= '0;
                        tx_out_q  <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_out_q  <= data_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA_BURST;
                    end
                end
                DATA_BURST: begin
                    if (bit_tick) begin
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN) begin
                                tx_out_q <= parity_bit;
                                state_q  <= PARITY;
                            end else begin
                                tx_out_q <= 1'b1;
                                state_q  <= STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_out_q  <= data_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_out_q <= 1'b1;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        tx_out_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    tx_out_q <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_busy  = (state_q != IDLE);
    assign tx_ready = !tx_busy;
    assign tx_out   = tx_out_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances at 8 clocks per bit (no parity, even parity, odd parity).
module tb_uart_tx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       cur_vld;
    int         sel;
    logic       v0;
    logic       vp;
    logic [2:0] rdy, txo, busy, done;

    always #5 clk = ~clk;

    assign v0 = cur_vld && (sel == 0);
    assign vp = cur_vld && (sel == 1);

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .tx_clk(clk), .rst(rst), .tx_valid(v0), .tx_data(data),
        .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .tx_clk(clk), .rst(rst), .tx_valid(vp), .tx_data(data),
        .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
        .tx_clk(clk), .rst(rst), .tx_valid(vp), .tx_data(data),
        .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    logic [2:0] ln [0:255];
    logic [2:0] dn [0:255];
    logic [2:0] rd [0:255];
    logic [2:0] bz [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int rb_viol  = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (rdy !== ~busy)) rb_viol++;
    end

    // Samples every DUT once per cycle on the falling edge, applying per-cycle stimulus events.
    task automatic capture(input int n, input int vld_off, input int chg_at, input logic [7:0] chg_val,
                           input int pulse_at, input int rst_at);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ln[k] = txo;
            dn[k] = done;
            rd[k] = rdy;
            bz[k] = busy;
            if (k == vld_off) cur_vld = 1'b0;
            if (k == chg_at) data = chg_val;
            if (k == pulse_at) cur_vld = 1'b1;
            if (pulse_at != 0 && k == pulse_at + 1) cur_vld = 1'b0;
            if (k == rst_at) rst = 1'b1;
            if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic start_send(input int s, input logic [7:0] b);
        @(negedge clk);
        sel     = s;
        data    = b;
        cur_vld = 1'b1;
    endtask

    function automatic logic [31:0] frame_bits(input int d, input int first, input int nb);
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[i] = ln[first + i*CPB + CPB/2][d];
        return v;
    endfunction

    function automatic int hold_err(input int d, input int first, input int nb);
        int e = 0;
        for (int k = first; k < first + nb*CPB; k++)
            if (ln[k][d] !== ln[first + ((k - first) / CPB) * CPB][d]) e++;
        return e;
    endfunction

    function automatic int done_count(input int d, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (dn[k][d] === 1'b1) c++;
        return c;
    endfunction

    function automatic int done_pos(input int d, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (dn[k][d] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int idle_count(input int d, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++)
            if (ln[k][d] === 1'b1 && rd[k][d] === 1'b1 && bz[k][d] === 1'b0 && dn[k][d] === 1'b0) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_tot;
        rst     = 1'b1;
        data    = 8'h00;
        cur_vld = 1'b0;
        sel     = 0;
        repeat (3) @(negedge clk);
        check("rst_out",   32'(txo),  32'h7);
        check("rst_ready", 32'(rdy),  32'h7);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle for 100 cycles
        capture(100, 0, 0, 8'h00, 0, 0);
        idle_tot = 0;
        for (int d = 0; d < 3; d++) idle_tot += idle_count(d, 1, 100);
        check("idle100", 32'(idle_tot), 32'd300);

        // 0xA5 without parity
        start_send(0, 8'hA5);
        capture(90, 1, 0, 8'h00, 0, 0);
        check("a5_frame",    frame_bits(0, 1, 10), 32'h34A);
        check("a5_hold",     32'(hold_err(0, 1, 10)), 32'd0);
        check("a5_done_cnt", 32'(done_count(0, 1, 90)), 32'd1);
        check("a5_done_pos", 32'(done_pos(0, 1, 90)), 32'd80);
        check("a5_busy_mid", 32'(bz[40][0]), 32'd1);
        check("a5_idle_after", 32'(idle_count(0, 81, 90)), 32'd10);

        // 0x07 with even and odd parity
        start_send(1, 8'h07);
        capture(100, 1, 0, 8'h00, 0, 0);
        check("par_even_frame", frame_bits(1, 1, 11), 32'h60E);
        check("par_odd_frame",  frame_bits(2, 1, 11), 32'h40E);
        check("par_even_hold",  32'(hold_err(1, 1, 11)), 32'd0);
        check("par_odd_hold",   32'(hold_err(2, 1, 11)), 32'd0);
        check("par_even_done",  32'(done_pos(1, 1, 100)), 32'd88);
        check("par_odd_done",   32'(done_pos(2, 1, 100)), 32'd88);
        check("par_done_cnt",   32'(done_count(1, 1, 100) + done_count(2, 1, 100)), 32'd2);

        // Back-to-back with tx_valid held: 0x55 then 0xAA
        start_send(0, 8'h55);
        capture(180, 82, 1, 8'hAA, 0, 0);
        check("b2b_frame1",  frame_bits(0, 1, 10), 32'h2AA);
        check("b2b_frame2",  frame_bits(0, 82, 10), 32'h354);
        check("b2b_hold",    32'(hold_err(0, 1, 10) + hold_err(0, 82, 10)), 32'd0);
        check("b2b_gap",     32'(idle_count(0, 81, 81)), 32'd1);
        check("b2b_done1",   32'(done_pos(0, 1, 81)), 32'd80);
        check("b2b_done2",   32'(done_pos(0, 82, 180)), 32'd161);
        check("b2b_donecnt", 32'(done_count(0, 1, 180)), 32'd2);
        check("b2b_tail",    32'(idle_count(0, 162, 180)), 32'd19);

        // Data change and tx_valid pulse while busy
        start_send(0, 8'h3C);
        capture(100, 1, 10, 8'hFF, 20, 0);
        check("busy_frame",   frame_bits(0, 1, 10), 32'h278);
        check("busy_hold",    32'(hold_err(0, 1, 10)), 32'd0);
        check("busy_noextra", 32'(idle_count(0, 81, 100)), 32'd20);
        check("busy_donecnt", 32'(done_count(0, 1, 100)), 32'd1);

        // Reset during data bit 3 of 0xF0
        start_send(0, 8'hF0);
        capture(60, 1, 0, 8'h00, 0, 35);
        check("rst_mid_before", 32'(ln[35][0]), 32'd0);
        check("rst_mid_after",  32'(idle_count(0, 36, 60)), 32'd25);
        check("rst_mid_nodone", 32'(done_count(0, 1, 60)), 32'd0);

        start_send(0, 8'hA5);
        capture(85, 1, 0, 8'h00, 0, 0);
        check("post_rst_frame", frame_bits(0, 1, 10), 32'h34A);
        check("post_rst_done",  32'(done_pos(0, 1, 85)), 32'd80);

        check("ready_eq_not_busy", 32'(rb_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
